// File: rtl/ray_bbox_intersect_pipe_pkg.sv
// Shared constants and saturating fixed-point helpers for the ray/box slab pipeline.
package ray_bbox_intersect_pipe_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int FRAC_W_DEF = 12;
  localparam int TAG_W_DEF  = 8;

  localparam int AX_X   = 0;
  localparam int AX_Y   = 1;
  localparam int AX_Z   = 2;
  localparam int NUM_AX = 3;

  // A (DATA_W+1)-bit difference times a DATA_W-bit inverse fits exactly for DATA_W <= 31.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic wide_t sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic wide_t sat_shift_mul(input wide_t d, input wide_t inv,
                                          input int frac, input int w);
    wide_t prod;
    wide_t shifted;
    prod    = d * inv;
    shifted = prod >>> frac;
    if (shifted > sat_max(w)) begin
      return sat_max(w);
    end else if (shifted < sat_min(w)) begin
      return sat_min(w);
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/ray_bbox_intersect_pipe_if.sv
// Request/response bundle of the slab pipeline; vectors are packed {z,y,x} and {tmax,tmin}.
interface ray_bbox_intersect_pipe_if #(
  parameter int DATA_W = 24,
  parameter int TAG_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [TAG_W-1:0]      in_tag;
  logic [3*DATA_W-1:0]   ray_orig;
  logic [3*DATA_W-1:0]   inv_ray_dir;
  logic [3*DATA_W-1:0]   box_min;
  logic [3*DATA_W-1:0]   box_max;
  logic [2*DATA_W-1:0]   prev_range;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_hit;
  logic [2*DATA_W-1:0]   out_range;

  modport master (
    output in_valid, in_tag, ray_orig, inv_ray_dir, box_min, box_max, prev_range, out_ready,
    input  in_ready, out_valid, out_tag, out_hit, out_range
  );

  modport slave (
    input  in_valid, in_tag, ray_orig, inv_ray_dir, box_min, box_max, prev_range, out_ready,
    output in_ready, out_valid, out_tag, out_hit, out_range
  );
endinterface

// File: rtl/ray_bbox_intersect_pipe_slab_axis.sv
// One axis of the slab test: subtract (S1), scaled multiply (S2), swap/parallel/clamp (S3).
module ray_bbox_intersect_pipe_slab_axis
  import ray_bbox_intersect_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_adv,
  input  logic signed [DATA_W-1:0] i_orig,
  input  logic signed [DATA_W-1:0] i_inv,
  input  logic signed [DATA_W-1:0] i_box_min,
  input  logic signed [DATA_W-1:0] i_box_max,
  input  logic signed [DATA_W-1:0] i_prev_tmin,
  input  logic signed [DATA_W-1:0] i_prev_tmax,
  output logic signed [DATA_W-1:0] o_tmin,
  output logic signed [DATA_W-1:0] o_tmax
);

  localparam logic signed [DATA_W-1:0] SAT_MAX_D = DATA_W'(sat_max(DATA_W));
  localparam logic signed [DATA_W-1:0] SAT_MIN_D = DATA_W'(sat_min(DATA_W));

  logic signed [DATA_W:0]   r_d0, r_d1;
  logic signed [DATA_W-1:0] r_inv1;
  logic                     r_par1, r_inside1;
  logic signed [DATA_W-1:0] r_p0, r_p1;
  logic                     r_neg2, r_par2, r_inside2;
  logic signed [DATA_W-1:0] r_tmin, r_tmax;
  logic signed [DATA_W-1:0] w_t0, w_t1, w_tmin, w_tmax;

  // S1/S2 registers: one extra bit keeps the subtraction exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d0      <= '0;
      r_d1      <= '0;
      r_inv1    <= '0;
      r_par1    <= 1'b0;
      r_inside1 <= 1'b0;
      r_p0      <= '0;
      r_p1      <= '0;
      r_neg2    <= 1'b0;
      r_par2    <= 1'b0;
      r_inside2 <= 1'b0;
    end else if (i_adv) begin
      r_d0      <= {i_box_min[DATA_W-1], i_box_min} - {i_orig[DATA_W-1], i_orig};
      r_d1      <= {i_box_max[DATA_W-1], i_box_max} - {i_orig[DATA_W-1], i_orig};
      r_inv1    <= i_inv;
      r_par1    <= (i_inv == '0);
      r_inside1 <= (i_box_min <= i_orig) && (i_orig <= i_box_max);
      r_p0      <= DATA_W'(sat_shift_mul(wide_t'(r_d0), wide_t'(r_inv1), FRAC_W, DATA_W));
      r_p1      <= DATA_W'(sat_shift_mul(wide_t'(r_d1), wide_t'(r_inv1), FRAC_W, DATA_W));
      r_neg2    <= r_inv1[DATA_W-1];
      r_par2    <= r_par1;
      r_inside2 <= r_inside1;
    end
  end

  // A parallel ray either spans the whole line (origin inside the slab) or nothing.
  always_comb begin
    w_t0 = r_p0;
    w_t1 = r_p1;
    if (r_par2) begin
      if (r_inside2) begin
        w_t0 = SAT_MIN_D;
        w_t1 = SAT_MAX_D;
      end else begin
        w_t0 = SAT_MAX_D;
        w_t1 = SAT_MIN_D;
      end
    end else if (r_neg2) begin
      w_t0 = r_p1;
      w_t1 = r_p0;
    end else begin
      w_t0 = r_p0;
      w_t1 = r_p1;
    end
    w_tmin = (w_t0 > i_prev_tmin) ? w_t0 : i_prev_tmin;
    w_tmax = (w_t1 < i_prev_tmax) ? w_t1 : i_prev_tmax;
  end

  // S3 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmin <= '0;
      r_tmax <= '0;
    end else if (i_adv) begin
      r_tmin <= w_tmin;
      r_tmax <= w_tmax;
    end
  end

  assign o_tmin = r_tmin;
  assign o_tmax = r_tmax;

endmodule

// File: rtl/ray_bbox_intersect_pipe.sv
// Four-stage ray/AABB slab test with a global-stall valid/ready pipeline and tag pass-through.
module ray_bbox_intersect_pipe
  import ray_bbox_intersect_pipe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int INCLUSIVE = 1
) (
  input logic                     clk,
  input logic                     rst,
  ray_bbox_intersect_pipe_if.slave bus
);

  logic                     w_adv;
  logic                     r_vld_s1, r_vld_s2, r_vld_s3;
  logic [TAG_W-1:0]         r_tag_s1, r_tag_s2, r_tag_s3;
  logic [2*DATA_W-1:0]      r_prev_s1, r_prev_s2;
  logic                     r_out_valid, r_out_hit;
  logic [TAG_W-1:0]         r_out_tag;
  logic [2*DATA_W-1:0]      r_out_range;
  logic signed [DATA_W-1:0] w_tmin [NUM_AX];
  logic signed [DATA_W-1:0] w_tmax [NUM_AX];
  logic signed [DATA_W-1:0] w_rmin, w_rmax;
  logic                     w_hit;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] smin(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Every stage moves together; a full output stage blocks the whole pipe.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar g = 0; g < NUM_AX; g++) begin : g_axis
    ray_bbox_intersect_pipe_slab_axis #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_slab (
      .clk         (clk),
      .rst         (rst),
      .i_adv       (w_adv),
      .i_orig      (bus.ray_orig[g*DATA_W +: DATA_W]),
      .i_inv       (bus.inv_ray_dir[g*DATA_W +: DATA_W]),
      .i_box_min   (bus.box_min[g*DATA_W +: DATA_W]),
      .i_box_max   (bus.box_max[g*DATA_W +: DATA_W]),
      .i_prev_tmin (r_prev_s2[DATA_W-1:0]),
      .i_prev_tmax (r_prev_s2[2*DATA_W-1:DATA_W]),
      .o_tmin      (w_tmin[g]),
      .o_tmax      (w_tmax[g])
    );
  end

  // S4 reduction across the three axes.
  always_comb begin
    w_rmin = smax(smax(w_tmin[AX_X], w_tmin[AX_Y]), w_tmin[AX_Z]);
    w_rmax = smin(smin(w_tmax[AX_X], w_tmax[AX_Y]), w_tmax[AX_Z]);
    w_hit  = (INCLUSIVE != 0) ? (w_rmin <= w_rmax) : (w_rmin < w_rmax);
  end

  // Valid chain plus the tag/interval side-band that rides alongside the slab data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_s1    <= 1'b0;
      r_vld_s2    <= 1'b0;
      r_vld_s3    <= 1'b0;
      r_tag_s1    <= '0;
      r_tag_s2    <= '0;
      r_tag_s3    <= '0;
      r_prev_s1   <= '0;
      r_prev_s2   <= '0;
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_tag   <= '0;
      r_out_range <= '0;
    end else if (w_adv) begin
      r_vld_s1    <= bus.in_valid;
      r_vld_s2    <= r_vld_s1;
      r_vld_s3    <= r_vld_s2;
      r_tag_s1    <= bus.in_tag;
      r_tag_s2    <= r_tag_s1;
      r_tag_s3    <= r_tag_s2;
      r_prev_s1   <= bus.prev_range;
      r_prev_s2   <= r_prev_s1;
      r_out_valid <= r_vld_s3;
      r_out_hit   <= w_hit;
      r_out_tag   <= r_tag_s3;
      r_out_range <= {w_rmax, w_rmin};
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_hit   = r_out_hit;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_range = r_out_range;

endmodule

// File: tb/tb_ray_bbox_intersect_pipe.sv
// Directed vectors into an inclusive and an exclusive instance; per-instance scoreboards check results.
module tb_ray_bbox_intersect_pipe;
  import ray_bbox_intersect_pipe_pkg::*;

  localparam int DW = 24;
  localparam int TW = 8;

  localparam logic signed [DW-1:0] P0    = 24'sd0;
  localparam logic signed [DW-1:0] P1    = 24'sd1;
  localparam logic signed [DW-1:0] Q1    = 24'sd4096;
  localparam logic signed [DW-1:0] Q15   = 24'sd6144;
  localparam logic signed [DW-1:0] Q2    = 24'sd8192;
  localparam logic signed [DW-1:0] Q3    = 24'sd12288;
  localparam logic signed [DW-1:0] Q5    = 24'sd20480;
  localparam logic signed [DW-1:0] Q6    = 24'sd24576;
  localparam logic signed [DW-1:0] QBIG  = 24'sd409600;
  localparam logic signed [DW-1:0] N1    = -24'sd4096;
  localparam logic signed [DW-1:0] SMAX  = 24'sh7FFFFF;
  localparam logic signed [DW-1:0] SMIN  = 24'sh800000;
  localparam logic signed [DW-1:0] NSMAX = 24'sh800001;

  typedef struct packed {
    logic [TW-1:0]   tag;
    logic            hit;
    logic [2*DW-1:0] rng;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [TW-1:0]   in_tag = '0;
  logic [3*DW-1:0] ray_orig = '0, inv_ray_dir = '0, box_min = '0, box_max = '0;
  logic [2*DW-1:0] prev_range = '0;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q_i[$];
  exp_t q_e[$];

  ray_bbox_intersect_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus_i ();
  ray_bbox_intersect_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus_e ();

  assign bus_i.in_valid = in_valid;     assign bus_e.in_valid = in_valid;
  assign bus_i.in_tag = in_tag;         assign bus_e.in_tag = in_tag;
  assign bus_i.ray_orig = ray_orig;     assign bus_e.ray_orig = ray_orig;
  assign bus_i.inv_ray_dir = inv_ray_dir; assign bus_e.inv_ray_dir = inv_ray_dir;
  assign bus_i.box_min = box_min;       assign bus_e.box_min = box_min;
  assign bus_i.box_max = box_max;       assign bus_e.box_max = box_max;
  assign bus_i.prev_range = prev_range; assign bus_e.prev_range = prev_range;
  assign bus_i.out_ready = out_ready;   assign bus_e.out_ready = out_ready;

  ray_bbox_intersect_pipe #(.DATA_W(DW), .FRAC_W(12), .TAG_W(TW), .INCLUSIVE(1)) dut_i (
    .clk (clk), .rst (rst), .bus (bus_i)
  );
  ray_bbox_intersect_pipe #(.DATA_W(DW), .FRAC_W(12), .TAG_W(TW), .INCLUSIVE(0)) dut_e (
    .clk (clk), .rst (rst), .bus (bus_e)
  );

  function automatic logic [3*DW-1:0] v3(input logic signed [DW-1:0] x,
                                         input logic signed [DW-1:0] y,
                                         input logic signed [DW-1:0] z);
    return {z, y, x};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [TW-1:0] tag, input logic [3*DW-1:0] o,
                      input logic [3*DW-1:0] inv, input logic [3*DW-1:0] bmn,
                      input logic [3*DW-1:0] bmx, input logic signed [DW-1:0] ptmin,
                      input logic signed [DW-1:0] ptmax, input logic signed [DW-1:0] etmin,
                      input logic signed [DW-1:0] etmax, input logic hi, input logic he);
    logic rdy;
    bit   accepted;
    accepted = 0;
    @(negedge clk);
    in_valid = 1'b1; in_tag = tag; ray_orig = o; inv_ray_dir = inv;
    box_min = bmn; box_max = bmx; prev_range = {ptmax, ptmin};
    for (int c = 0; c < 200; c++) begin
      #1 rdy = bus_i.in_ready;
      @(posedge clk);
      if (rdy) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) begin
      q_i.push_back('{tag: tag, hit: hi, rng: {etmax, etmin}});
      q_e.push_back('{tag: tag, hit: he, rng: {etmax, etmin}});
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tag 0x%0h never accepted", tag);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((q_i.size() != 0 || q_e.size() != 0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(q_i.size() + q_e.size()), 64'd0);
  endtask

  // Scoreboard for the inclusive instance.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus_i.out_valid && bus_i.out_ready) begin
      if (q_i.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_incl_unexpected: got tag 0x%0h with nothing pending", bus_i.out_tag);
      end else begin
        e = q_i.pop_front();
        check($sformatf("out_incl_tag%0h", e.tag),
              64'({bus_i.out_tag, bus_i.out_hit, bus_i.out_range}), 64'(e));
      end
    end
  end

  // Scoreboard for the exclusive instance.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus_e.out_valid && bus_e.out_ready) begin
      if (q_e.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_excl_unexpected: got tag 0x%0h with nothing pending", bus_e.out_tag);
      end else begin
        e = q_e.pop_front();
        check($sformatf("out_excl_tag%0h", e.tag),
              64'({bus_e.out_tag, bus_e.out_hit, bus_e.out_range}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus_i.out_valid), 64'd0);
    check("rst_out_hit",   64'(bus_i.out_hit),   64'd0);
    check("rst_out_tag",   64'(bus_i.out_tag),   64'd0);
    check("rst_out_range", 64'(bus_i.out_range), 64'd0);
    check("rst_in_ready",  64'(bus_i.in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    send(8'h01, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
    send(8'h02, v3(Q3,P0,P0), v3(N1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
    send(8'h03, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q5,Q1), v3(Q2,Q6,Q2), P0, QBIG, Q5, Q2, 1'b0, 1'b0);
    send(8'h04, v3(Q15,P0,P0), v3(P0,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
    send(8'h05, v3(Q3,P0,P0), v3(P0,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, SMAX, SMIN, 1'b0, 1'b0);
    send(8'h06, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), Q2, QBIG, Q2, Q2, 1'b1, 1'b0);
    send(8'h07, v3(P0,P0,P0), v3(SMAX,P0,P0), v3(P0,N1,N1), v3(SMAX,Q1,Q1), P0, SMAX, P0, SMAX, 1'b1, 1'b1);
    send(8'h08, v3(P0,P0,P0), v3(NSMAX,P0,P0), v3(P0,N1,N1), v3(SMAX,Q1,Q1), SMIN, SMAX, SMIN, P0, 1'b1, 1'b1);
    send(8'h09, v3(P1,P0,P0), v3(P1,P0,P0), v3(P0,N1,N1), v3(Q1,Q1,Q1), SMIN, SMAX, -24'sd1, P0, 1'b1, 1'b1);
    send(8'h0A, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, Q15, Q1, Q15, 1'b1, 1'b1);
    drain("drain_directed");

    // Backpressure: the pipe fills, stalls, then releases tags 0..5 in order.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 6; t++) begin
          if (t % 2 == 0) begin
            send(8'(t), v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
          end else begin
            send(8'(t), v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q5,Q1), v3(Q2,Q6,Q2), P0, QBIG, Q5, Q2, 1'b0, 1'b0);
          end
        end
      end
      begin
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          #1;
          if (i == 5 || i == 9) begin
            check($sformatf("stall_in_ready_c%0d", i),  64'(bus_i.in_ready),  64'd0);
            check($sformatf("stall_out_valid_c%0d", i), 64'(bus_i.out_valid), 64'd1);
            check($sformatf("stall_out_tag_c%0d", i),   64'(bus_i.out_tag),   64'd0);
            check($sformatf("stall_out_hit_c%0d", i),   64'(bus_i.out_hit),   64'd1);
            check($sformatf("stall_out_range_c%0d", i), 64'(bus_i.out_range), 64'({Q2, Q1}));
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with three requests in flight: they must vanish.
    send(8'h30, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
    send(8'h31, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
    send(8'h32, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus_i.out_valid), 64'd0);
    check("midrst_out_tag",   64'(bus_i.out_tag),   64'd0);
    check("midrst_out_range", 64'(bus_i.out_range), 64'd0);
    q_i.delete();
    q_e.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send(8'h40, v3(P0,P0,P0), v3(Q1,Q1,Q1), v3(Q1,Q1,Q1), v3(Q2,Q2,Q2), P0, QBIG, Q1, Q2, 1'b1, 1'b1);
    drain("drain_after_reset");
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
